dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the processor's load/store port: the processor is the initiator, this block is the far end.
- Accepts one 64-bit doubleword read or write request at a time and returns a response after a programmable latency.
- Used to exercise the core against non-zero memory latency and to serve the pass-code load that benches check on the memory output.
- Sits between the datapath memory stage and the word-array storage.

Parameters:
- DEPTH_WORDS, 32, number of 64-bit words; power of two, >= 2.
- LATENCY, 1, cycles from request acceptance to rsp_valid; 1..15.

Ports:
- CLK  in  1  single clock; all state updates on posedge.
- resetl  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- req_ready  out  1  responder can accept a request.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  64  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset (resetl=0, asynchronous): FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready at edge N, latch addr/write/wdata.
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with cnt=LATENCY-1.
- WAIT: req_ready=0. Decrement cnt each edge; when cnt==1, go to RESP at that edge.
- rsp_valid first rises in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Entry to RESP edge (commit edge): perform access.
  - Word index = addr[3+log2(DEPTH_WORDS)-1:3].
  - Load: rsp_rdata=mem[idx], rsp_err=0.
  - Store: mem[idx]=wdata, rsp_rdata=0, rsp_err=0.
- Error conditions: addr[2:0]!=0, or addr[63:3] >= DEPTH_WORDS.
  - rsp_err=1, rsp_rdata=0, no memory write.
- RESP: rsp_valid=1, req_ready=0. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that edge: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready returns to 1 in the following cycle. No same-cycle response/request overlap.
- Back-pressure: rsp_ready low holds RESP indefinitely with outputs frozen.
- req_valid while req_ready=0 is ignored, not queued. The initiator must hold the request until it sees req_ready.
- Read-after-write to the same address on consecutive transactions returns the new data (the write is committed before the next acceptance).
- Reset mid-operation:
  - Asserted in WAIT: the pending store is dropped, memory unchanged.
  - Asserted in RESP: the store is already committed; the response is discarded.
- Counter width: 4 bits. LATENCY outside 1..15 is a parameter error; the implementation flags it with an elaboration-time check.

Optional Feature:
- Macro DMEM_WSTRB_EN.
- Defined:
  - Adds input req_wstrb[7:0]. Store writes byte lane i (bits 8i+7:8i) only where wstrb[i]=1.
  - wstrb=8'h00 is a valid no-op store: rsp_err=0.
  - The alignment check is unchanged.
- Undefined: no req_wstrb port; every store writes all 8 bytes.

Test Plan:
- LATENCY=1: store 64'h123456789ABCDEF0 to 0x28, then load 0x28 with rsp_ready=1 -> load rsp_valid exactly 1 cycle after acceptance, rsp_rdata=64'h123456789ABCDEF0, rsp_err=0.
- LATENCY=4: load 0x0 after storing 64'hF -> req_ready=0 for the 4 cycles after acceptance, rsp_valid rises 4 cycles after acceptance, rdata=64'hF; req_ready=1 one cycle after the response handshake.
- Back-pressure: hold rsp_ready=0 for 10 cycles during a load response -> rsp_valid, rsp_rdata and rsp_err are stable throughout; a second req_valid is ignored (no second response).
- Errors:
  - Load 0x0C -> rsp_err=1, rdata=0.
  - Store 64'hDEAD to DEPTH_WORDS*8 -> rsp_err=1; a subsequent load of 0x0 returns its old value.
- Reset mid-op: LATENCY=4, store 64'hAA to 0x10, assert resetl=0 for 1 cycle during WAIT -> outputs reset immediately, req_ready=1; a later load of 0x10 returns the prior value, not 64'hAA.
- DMEM_WSTRB_EN: pre-store 64'hFFFFFFFFFFFFFFFF at 0x8, store 64'h0 with wstrb=8'h0F -> load returns 64'hFFFFFFFF00000000.

Source files
------------

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the load/store initiator and dmem_responder (req_wstrb present when DMEM_WSTRB_EN is defined)
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
`ifdef DMEM_WSTRB_EN
  logic [7:0]  req_wstrb;
`endif
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_WSTRB_EN
  modport master (output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_write, req_addr, req_wdata, rsp_ready,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding 64-bit load/store responder with programmable latency; DMEM_WSTRB_EN adds byte write strobes
module dmem_responder #(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY = 1
) (
  input logic CLK,
  input logic resetl,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (LATENCY < 1 || LATENCY > 15) begin : g_lat_chk
    $error("dmem_responder: LATENCY must be within 1..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_chk
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic write_q, err_q;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [7:0] strb_q, req_strb;
  logic [63:0] mem [DEPTH_WORDS];
  logic in_idle, a_write, a_err, commit, done;
  logic [63:0] a_addr, a_wdata;
  logic [7:0] a_strb;
  logic [AW-1:0] idx;
`ifdef DMEM_WSTRB_EN
  assign req_strb = bus.req_wstrb;
`else
  assign req_strb = 8'hFF;
`endif
  assign in_idle = state == IDLE;
  // With LATENCY=1 the commit edge is the acceptance edge, so operands bypass the request latch
  assign a_write = in_idle ? bus.req_write : write_q;
  assign a_addr = in_idle ? bus.req_addr : addr_q;
  assign a_wdata = in_idle ? bus.req_wdata : wdata_q;
  assign a_strb = in_idle ? req_strb : strb_q;
  assign idx = a_addr[3+AW-1:3];
  assign a_err = (|a_addr[2:0]) || (|a_addr[63:3+AW]);
  assign commit = state_n == RESP && state != RESP;
  assign done = state == RESP && bus.rsp_ready;
  assign bus.req_ready = in_idle;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
  // Next state and latency countdown
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = (LATENCY == 1) ? RESP : WAIT;
        cnt_n = 4'(LATENCY - 1);
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        state_n = (cnt == 4'd1) ? RESP : WAIT;
      end
      RESP: state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // State, request latch and response registers; response held until the handshake clears it
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      cnt <= 4'd0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (in_idle && bus.req_valid) begin
        write_q <= bus.req_write;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        strb_q <= req_strb;
      end
      if (commit) begin
        rdata_q <= (!a_write && !a_err) ? mem[idx] : '0;
        err_q <= a_err;
      end else if (done) begin
        rdata_q <= '0;
        err_q <= 1'b0;
      end
    end
  end
  // Storage is not reset; stores land on the commit edge, never while reset is asserted
  always_ff @(posedge CLK) begin
    if (commit && a_write && !a_err && resetl)
      for (int i = 0; i < 8; i++)
        if (a_strb[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder at LATENCY 1 and 4 against a cycle-level reference model
module tb_dmem_responder;
  logic clk = 1'b0;
  logic resetl = 1'b0;
  always #5 clk = ~clk;
  dmem_responder_if i1 ();
  dmem_responder_if i4 ();
  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u1 (.CLK(clk), .resetl(resetl), .bus(i1));
  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(4)) u4 (.CLK(clk), .resetl(resetl), .bus(i4));
  logic sel = 1'b0;
  logic b_valid = 1'b0, b_write = 1'b0, b_rready = 1'b0;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [7:0] b_wstrb = 8'hFF;
  assign i1.req_valid = !sel && b_valid;
  assign i4.req_valid = sel && b_valid;
  assign i1.rsp_ready = !sel && b_rready;
  assign i4.rsp_ready = sel && b_rready;
  assign i1.req_write = b_write;
  assign i4.req_write = b_write;
  assign i1.req_addr = b_addr;
  assign i4.req_addr = b_addr;
  assign i1.req_wdata = b_wdata;
  assign i4.req_wdata = b_wdata;
`ifdef DMEM_WSTRB_EN
  assign i1.req_wstrb = b_wstrb;
  assign i4.req_wstrb = b_wstrb;
`endif
  logic a_ready, a_valid, a_err;
  logic [63:0] a_rdata;
  assign a_ready = sel ? i4.req_ready : i1.req_ready;
  assign a_valid = sel ? i4.rsp_valid : i1.rsp_valid;
  assign a_err = sel ? i4.rsp_err : i1.rsp_err;
  assign a_rdata = sel ? i4.rsp_rdata : i1.rsp_rdata;
  int total = 0, bad = 0;
  logic chk_en = 1'b0;
  logic e_ready = 1'b1, e_valid = 1'b0, e_err = 1'b0;
  logic [63:0] e_rdata = '0;
  logic [63:0] mm [2][32];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(a_ready), 64'(e_ready));
      chk("rsp_valid", 64'(a_valid), 64'(e_valid));
      chk("rsp_err", 64'(a_err), 64'(e_err));
      chk("rsp_rdata", a_rdata, e_rdata);
    end
  end
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                      input int hold, input logic extra, output logic [63:0] got, output logic got_err);
    int lat, idx;
    logic err;
    logic [63:0] rd;
    logic [7:0] strb;
    lat = sel ? 4 : 1;
`ifdef DMEM_WSTRB_EN
    strb = s;
`else
    strb = 8'hFF;
`endif
    err = (a % 8 != 0) || ((a >> 3) >= 64'd32);
    idx = int'((a >> 3) % 32);
    rd = (!w && !err) ? mm[sel][idx] : 64'd0;
    if (w && !err)
      for (int i = 0; i < 8; i++)
        if (strb[i]) mm[sel][idx][8*i +: 8] = d[8*i +: 8];
    b_valid = 1'b1;
    b_write = w;
    b_addr = a;
    b_wdata = d;
    b_wstrb = s;
    @(posedge clk); #1;
    b_valid = 1'b0;
    if (extra) begin
      b_valid = 1'b1;
      b_write = 1'b1;
      b_addr = 64'h0;
      b_wdata = 64'hBAD;
    end
    e_ready = 1'b0;
    e_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
    end
    e_valid = 1'b1;
    e_rdata = rd;
    e_err = err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
    end
    b_valid = 1'b0;
    b_rready = 1'b1;
    got = a_rdata;
    got_err = a_err;
    @(posedge clk); #1;
    b_rready = 1'b0;
    e_valid = 1'b0;
    e_rdata = '0;
    e_err = 1'b0;
    e_ready = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    logic [63:0] g, a;
    logic ge;
    #2;
    chk("rst_ready1", 64'(i1.req_ready), 64'd1);
    chk("rst_valid1", 64'(i1.rsp_valid), 64'd0);
    chk("rst_rdata4", i4.rsp_rdata, 64'd0);
    chk("rst_err4", 64'(i4.rsp_err), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetl = 1'b1;
    chk_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int i = 0; i < 32; i++)
        xact(1'b1, 64'(i * 8), 64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, 0, 1'b0, g, ge);
    end
    sel = 1'b0;
    xact(1'b1, 64'h28, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 1'b0, g, ge);
    chk("st28_rdata", g, 64'd0);
    xact(1'b0, 64'h28, 64'h0, 8'hFF, 0, 1'b0, g, ge);
    chk("ld28_rdata", g, 64'h1234_5678_9ABC_DEF0);
    chk("ld28_err", 64'(ge), 64'd0);
    xact(1'b0, 64'h0C, 64'h0, 8'hFF, 1, 1'b0, g, ge);
    chk("mis_err", 64'(ge), 64'd1);
    chk("mis_rdata", g, 64'd0);
    xact(1'b1, 64'd256, 64'hDEAD, 8'hFF, 0, 1'b0, g, ge);
    chk("oor_err", 64'(ge), 64'd1);
    xact(1'b0, 64'h0, 64'h0, 8'hFF, 0, 1'b0, g, ge);
    chk("oor_old", g, 64'hA5A5_0000_0000_0000);
    xact(1'b0, 64'h28, 64'h0, 8'hFF, 10, 1'b1, g, ge);
    chk("bp_rdata", g, 64'h1234_5678_9ABC_DEF0);
    xact(1'b0, 64'h0, 64'h0, 8'hFF, 0, 1'b0, g, ge);
    chk("bp_ignored", g, 64'hA5A5_0000_0000_0000);
`ifdef DMEM_WSTRB_EN
    xact(1'b1, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0, g, ge);
    xact(1'b1, 64'h8, 64'h0, 8'h0F, 0, 1'b0, g, ge);
    xact(1'b0, 64'h8, 64'h0, 8'hFF, 0, 1'b0, g, ge);
    chk("wstrb_rdata", g, 64'hFFFF_FFFF_0000_0000);
    xact(1'b1, 64'h8, 64'h0, 8'h00, 0, 1'b0, g, ge);
    chk("wstrb0_err", 64'(ge), 64'd0);
    xact(1'b0, 64'h8, 64'h0, 8'hFF, 0, 1'b0, g, ge);
    chk("wstrb0_keep", g, 64'hFFFF_FFFF_0000_0000);
`endif
    sel = 1'b1;
    xact(1'b1, 64'h0, 64'hF, 8'hFF, 0, 1'b0, g, ge);
    xact(1'b0, 64'h0, 64'h0, 8'hFF, 2, 1'b0, g, ge);
    chk("l4_rdata", g, 64'hF);
    b_valid = 1'b1;
    b_write = 1'b1;
    b_addr = 64'h10;
    b_wdata = 64'hAA;
    @(posedge clk); #1;
    b_valid = 1'b0;
    e_ready = 1'b0;
    @(posedge clk); #1;
    #2;
    resetl = 1'b0;
    #1;
    e_ready = 1'b1;
    chk("midrst_ready", 64'(a_ready), 64'd1);
    chk("midrst_valid", 64'(a_valid), 64'd0);
    @(posedge clk); #1;
    resetl = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 64'h10, 64'h0, 8'hFF, 0, 1'b0, g, ge);
    chk("midrst_old", g, 64'hA5A5_0000_0000_0002);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      for (int n = 0; n < 60; n++) begin
        case ($urandom % 8)
          0: a = 64'(($urandom % 32) * 8 + 1 + $urandom % 7);
          1: a = {$urandom, $urandom} | 64'h100;
          default: a = 64'(($urandom % 32) * 8);
        endcase
        xact(1'($urandom % 2), a, {$urandom, $urandom}, 8'($urandom), int'($urandom % 4),
             1'($urandom % 4 == 0), g, ge);
      end
    end
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
